// File: rtl/rope_pkg.sv
// Shared types and default sizing for the rope physics sequencer and datapath.
package rope_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic PHASE_INTEGRATE = 1'b0;
  localparam logic PHASE_CONSTRAIN = 1'b1;

  localparam int DEF_N_NODES   = 5;
  localparam int DEF_ITERS     = 4;
  localparam int DEF_COORD_W   = 10;
  localparam int DEF_FRAME_DIV = 1000;

endpackage

// File: rtl/rope_step_sched_if.sv
// Op port between the step sequencer and the shared node-update unit, plus the latched anchor.
interface rope_step_sched_if #(
  parameter int IDX_W   = $clog2(rope_pkg::DEF_N_NODES),
  parameter int COORD_W = rope_pkg::DEF_COORD_W
);
  logic               upd_valid;
  logic               upd_ready;
  logic               upd_phase;
  logic [IDX_W-1:0]   upd_node;
  logic               upd_last;
  logic               upd_idle;
  logic [COORD_W-1:0] anchor_x;
  logic [COORD_W-1:0] anchor_y;

  modport master (
    output upd_valid, upd_phase, upd_node, upd_last, anchor_x, anchor_y,
    input  upd_ready, upd_idle
  );

  modport slave (
    input  upd_valid, upd_phase, upd_node, upd_last, anchor_x, anchor_y,
    output upd_ready, upd_idle
  );
endinterface

// File: rtl/rope_tick_gen.sv
// Physics step timebase: free-running 0..FRAME_DIV-1 counter while enabled, tick on the final count.
module rope_tick_gen #(
  parameter int FRAME_DIV = rope_pkg::DEF_FRAME_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);
  localparam int CW = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (!enable || count_q == LAST) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = (count_q == LAST);
endmodule

// File: rtl/rope_step_sched.sv
// Per-step sequencer: latches the mouse anchor on tick, then streams integrate and constraint
// ops to the node-update unit one handshake at a time, waits for it to drain and reports status.
module rope_step_sched
  import rope_pkg::*;
#(
  parameter int N_NODES   = DEF_N_NODES,
  parameter int ITERS     = DEF_ITERS,
  parameter int COORD_W   = DEF_COORD_W,
  parameter int FRAME_DIV = DEF_FRAME_DIV,
  parameter int IDX_W     = $clog2(N_NODES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [COORD_W-1:0] mouse_x,
  input  logic [COORD_W-1:0] mouse_y,
  rope_step_sched_if.master  upd,
  output logic               busy,
  output logic               step_done,
  output logic               overrun,
  output logic [15:0]        step_count
);
  localparam int ITER_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [IDX_W-1:0]  LAST_NODE = IDX_W'(N_NODES - 1);
  localparam logic [IDX_W-1:0]  LAST_SEG  = IDX_W'(N_NODES - 2);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(ITERS - 1);

  logic tick;

  rope_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  state_t             state_q, state_d;
  logic [COORD_W-1:0] anchor_x_q, anchor_x_d, anchor_y_q, anchor_y_d;
  logic               valid_q, valid_d, phase_q, phase_d, last_q, last_d;
  logic [IDX_W-1:0]   node_q, node_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic               busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
  logic [15:0]        count_q, count_d;

  always_comb begin
    state_d    = state_q;
    anchor_x_d = anchor_x_q;
    anchor_y_d = anchor_y_q;
    valid_d    = valid_q;
    phase_d    = phase_q;
    last_d     = last_q;
    node_d     = node_q;
    iter_d     = iter_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overrun_d  = overrun_q | (tick & busy_q);
    count_d    = count_q;

    case (state_q)
      IDLE: if (enable) state_d = WAIT;
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick) begin
          state_d    = ISSUE;
          anchor_x_d = mouse_x;
          anchor_y_d = mouse_y;
          busy_d     = 1'b1;
          valid_d    = 1'b1;
          phase_d    = PHASE_INTEGRATE;
          node_d     = IDX_W'(1);
          iter_d     = '0;
          last_d     = 1'b0;
        end
      end
      ISSUE: begin
        if (valid_q && upd.upd_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = DRAIN;
          end else begin
            if (phase_q == PHASE_INTEGRATE) begin
              if (node_q == LAST_NODE) begin
                phase_d = PHASE_CONSTRAIN;
                node_d  = '0;
              end else begin
                node_d = node_q + IDX_W'(1);
              end
            end else if (node_q == LAST_SEG) begin
              node_d = '0;
              iter_d = iter_q + ITER_W'(1);
            end else begin
              node_d = node_q + IDX_W'(1);
            end
            // The op being loaded is the last one when it is the final segment of the final pass.
            last_d = (phase_d == PHASE_CONSTRAIN) && (iter_d == LAST_ITER) && (node_d == LAST_SEG);
          end
        end
      end
      DRAIN: begin
        if (upd.upd_idle) begin
          state_d = DONE;
          done_d  = 1'b1;
          count_d = count_q + 16'd1;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = enable ? WAIT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      anchor_x_q <= '0;
      anchor_y_q <= '0;
      valid_q    <= 1'b0;
      phase_q    <= 1'b0;
      last_q     <= 1'b0;
      node_q     <= '0;
      iter_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      anchor_x_q <= anchor_x_d;
      anchor_y_q <= anchor_y_d;
      valid_q    <= valid_d;
      phase_q    <= phase_d;
      last_q     <= last_d;
      node_q     <= node_d;
      iter_q     <= iter_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      count_q    <= count_d;
    end
  end

  assign upd.upd_valid = valid_q;
  assign upd.upd_phase = phase_q;
  assign upd.upd_node  = node_q;
  assign upd.upd_last  = last_q;
  assign upd.anchor_x  = anchor_x_q;
  assign upd.anchor_y  = anchor_y_q;
  assign busy          = busy_q;
  assign step_done     = done_q;
  assign overrun       = overrun_q;
  assign step_count    = count_q;
endmodule

// File: tb/tb_rope_step_sched.sv
// Randomized scoreboard bench for rope_step_sched: expected op streams are queued per step and
// popped by a monitor on every handshake; scenario tasks check timing and status around them.
module tb_rope_step_sched;
  import rope_pkg::*;

  localparam int N_NODES   = DEF_N_NODES;
  localparam int ITERS     = DEF_ITERS;
  localparam int COORD_W   = DEF_COORD_W;
  localparam int FRAME_DIV = DEF_FRAME_DIV;
  localparam int IDX_W     = $clog2(N_NODES);
  localparam int N_OPS     = (N_NODES - 1) * (1 + ITERS);

  typedef struct {
    logic               phase;
    logic [IDX_W-1:0]   node;
    logic               last;
    logic [COORD_W-1:0] ax;
    logic [COORD_W-1:0] ay;
  } op_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [COORD_W-1:0] mouse_x = '0;
  logic [COORD_W-1:0] mouse_y = '0;
  logic busy, step_done, overrun;
  logic [15:0] step_count;

  rope_step_sched_if #(.IDX_W(IDX_W), .COORD_W(COORD_W)) upd_if ();

  rope_step_sched dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mouse_x    (mouse_x),
    .mouse_y    (mouse_y),
    .upd        (upd_if),
    .busy       (busy),
    .step_done  (step_done),
    .overrun    (overrun),
    .step_count (step_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_mode = 0;
  int hs_count = 0;
  int done_seen = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;
  int first_valid_cyc = 0;
  op_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference op stream for one step: integrate each free node, then ITERS sweeps of segments.
  task automatic push_step(input logic [COORD_W-1:0] mx, input logic [COORD_W-1:0] my);
    op_t ops[$];
    op_t o;
    for (int n = 1; n < N_NODES; n++) begin
      o = '{phase: 1'b0, node: IDX_W'(n), last: 1'b0, ax: mx, ay: my};
      ops.push_back(o);
    end
    for (int it = 0; it < ITERS; it++) begin
      for (int s = 0; s < N_NODES - 1; s++) begin
        o = '{phase: 1'b1, node: IDX_W'(s), last: 1'b0, ax: mx, ay: my};
        ops.push_back(o);
      end
    end
    ops[ops.size() - 1].last = 1'b1;
    foreach (ops[i]) exp_q.push_back(ops[i]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    int pc = 0;
    upd_if.upd_ready = 1'b1;
    upd_if.upd_idle  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: upd_if.upd_ready = 1'b1;
        1: begin
          upd_if.upd_ready = (pc == 0);
          pc = (pc + 1) % 3;
        end
        2: upd_if.upd_ready = 1'b0;
        default: upd_if.upd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks hold-under-stall and step completion.
  initial begin
    logic stall_prev = 1'b0;
    logic prev_valid = 1'b0;
    op_t held;
    op_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        hs_count = 0;
        done_seen = 0;
        stall_prev = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (stall_prev) begin
          check("hold_valid", 32'(upd_if.upd_valid), 32'(1));
          check("hold_phase", 32'(upd_if.upd_phase), 32'(held.phase));
          check("hold_node", 32'(upd_if.upd_node), 32'(held.node));
          check("hold_last", 32'(upd_if.upd_last), 32'(held.last));
        end
        if (upd_if.upd_valid && upd_if.upd_ready) begin
          check("op_expected", 32'(exp_q.size() > 0), 32'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("op_phase", 32'(upd_if.upd_phase), 32'(e.phase));
            check("op_node", 32'(upd_if.upd_node), 32'(e.node));
            check("op_last", 32'(upd_if.upd_last), 32'(e.last));
            check("anchor_x", 32'(upd_if.anchor_x), 32'(e.ax));
            check("anchor_y", 32'(upd_if.anchor_y), 32'(e.ay));
          end
          hs_count++;
          last_hs_cyc = cyc;
        end
        if (upd_if.upd_valid && !prev_valid) first_valid_cyc = cyc;
        stall_prev = upd_if.upd_valid && !upd_if.upd_ready;
        held = '{phase: upd_if.upd_phase, node: upd_if.upd_node, last: upd_if.upd_last,
                 ax: upd_if.anchor_x, ay: upd_if.anchor_y};
        prev_valid = upd_if.upd_valid;
        if (step_done) begin
          done_seen++;
          done_cyc = cyc;
          check("step_count", 32'(step_count), 32'(done_seen));
          check("ops_left_at_done", 32'(exp_q.size()), 32'(0));
        end
      end
    end
  end

  task automatic apply_stimulus_reset();
    reset = 1'b1;
    enable = 1'b0;
    ready_mode = 0;
    upd_if.upd_idle = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(upd_if.upd_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_overrun", 32'(overrun), 32'(0));
    check("rst_step_count", 32'(step_count), 32'(0));
    check("rst_anchor_x", 32'(upd_if.anchor_x), 32'(0));
    reset = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_hs(input int target, input int limit);
    for (int i = 0; i < limit && hs_count < target; i++) @(posedge clk);
    check("wait_handshakes", 32'(hs_count >= target), 32'(1));
    #1;
  endtask

  task automatic wait_done(input int target, input int limit);
    for (int i = 0; i < limit && done_seen < target; i++) @(posedge clk);
    check("wait_step_done", 32'(done_seen >= target), 32'(1));
    #1;
  endtask

  initial begin
    int en_cyc;
    int rise_cyc;
    logic [COORD_W-1:0] mx, my, mx2, my2;

    // Basic step with fixed anchor and free-flowing handshake.
    apply_stimulus_reset();
    mouse_x = 10'd202;
    mouse_y = 10'd50;
    push_step(10'd202, 10'd50);
    enable = 1'b1;
    en_cyc = cyc;
    wait_done(1, 1200);
    check("first_op_latency", 32'(first_valid_cyc - en_cyc), 32'(FRAME_DIV));
    check("done_after_first_op", 32'(done_cyc - first_valid_cyc), 32'(21));
    check("busy_after_step", 32'(busy), 32'(0));

    // Backpressure 1,0,0 with random anchor.
    apply_stimulus_reset();
    mx = COORD_W'($urandom);
    my = COORD_W'($urandom);
    mouse_x = mx;
    mouse_y = my;
    push_step(mx, my);
    ready_mode = 1;
    enable = 1'b1;
    wait_done(1, 1300);
    check("done_after_last_hs", 32'(done_cyc - last_hs_cyc), 32'(2));
    check("bp_handshakes", 32'(hs_count), 32'(N_OPS));

    // Drain waits on the update unit going idle.
    apply_stimulus_reset();
    upd_if.upd_idle = 1'b0;
    mx = COORD_W'($urandom);
    mouse_x = mx;
    push_step(mx, mouse_y);
    enable = 1'b1;
    wait_hs(N_OPS, 1200);
    repeat (7) @(posedge clk);
    #1;
    check("no_done_while_busy_unit", 32'(done_seen), 32'(0));
    upd_if.upd_idle = 1'b1;
    rise_cyc = cyc;
    wait_done(1, 50);
    check("done_after_idle", 32'(done_cyc - rise_cyc), 32'(1));

    // Long stall produces a sticky overrun on the next tick.
    apply_stimulus_reset();
    push_step(mouse_x, mouse_y);
    ready_mode = 2;
    enable = 1'b1;
    en_cyc = cyc;
    wait_cyc(en_cyc + 2 * FRAME_DIV - 1);
    check("overrun_before_tick", 32'(overrun), 32'(0));
    wait_cyc(en_cyc + 2 * FRAME_DIV);
    check("overrun_at_tick", 32'(overrun), 32'(1));
    wait_cyc(en_cyc + 2200);
    ready_mode = 0;
    wait_done(1, 200);
    check("overrun_sticky", 32'(overrun), 32'(1));
    check("overrun_hs", 32'(hs_count), 32'(N_OPS));

    // Enable dropped mid-step: step finishes, no further steps.
    apply_stimulus_reset();
    mx = COORD_W'($urandom);
    my = COORD_W'($urandom);
    mouse_x = mx;
    mouse_y = my;
    push_step(mx, my);
    ready_mode = 3;
    enable = 1'b1;
    wait_hs(4, 1200);
    enable = 1'b0;
    wait_done(1, 400);
    repeat (FRAME_DIV + 500) @(posedge clk);
    #1;
    check("disable_hs_total", 32'(hs_count), 32'(N_OPS));
    check("disable_valid", 32'(upd_if.upd_valid), 32'(0));
    check("disable_busy", 32'(busy), 32'(0));

    // Reset mid-issue, then fresh step with mouse moving mid-step.
    apply_stimulus_reset();
    mx = COORD_W'($urandom_range(1, 1023));
    mouse_x = mx;
    push_step(mx, mouse_y);
    enable = 1'b1;
    wait_hs(9, 1200);
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(upd_if.upd_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_node", 32'(upd_if.upd_node), 32'(0));
    check("midrst_anchor_x", 32'(upd_if.anchor_x), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    enable = 1'b0;
    reset = 1'b0;
    mx = COORD_W'($urandom);
    my = COORD_W'($urandom);
    mouse_x = mx;
    mouse_y = my;
    push_step(mx, my);
    enable = 1'b1;
    wait_hs(3, 1200);
    mx2 = ~mx;
    my2 = ~my;
    mouse_x = mx2;
    mouse_y = my2;
    @(posedge clk);
    #1;
    check("anchor_held_x", 32'(upd_if.anchor_x), 32'(mx));
    check("anchor_held_y", 32'(upd_if.anchor_y), 32'(my));
    wait_done(1, 200);
    push_step(mx2, my2);
    wait_done(2, 2000);
    check("two_steps_hs", 32'(hs_count), 32'(2 * N_OPS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
